// File: rtl/despachador_pkg.sv
// Shared types for the throw dispatcher: FSM state encoding and the width of the throw tally.
`timescale 1ns/1ps
package despachador_pkg;

   typedef enum logic [2:0] {
      REPOSO,
      ESPERA_LISTO,
      PULSO,
      DECREMENTAR,
      PAUSA,
      ERROR
   } estado_t;

   localparam int ANCHO_TIROS = 8;

   function automatic logic es_ocupado(input estado_t e);
      return !((e == REPOSO) || (e == ERROR));
   endfunction

endpackage

// File: rtl/despachador_tiros_if.sv
// Handshake bundle between the throw dispatcher, the pending-throw counter and the actuator.
`timescale 1ns/1ps
interface despachador_tiros_if;

   logic                                  clk_en_i;
   logic                                  hay_pendiente_i;
   logic                                  listo_i;
   logic                                  limpiar_i;
   logic                                  tirar_o;
   logic                                  decrementar_o;
   logic                                  ocupado_o;
   logic                                  error_o;
   logic [despachador_pkg::ANCHO_TIROS-1:0] tiros_o;

   // master is the dispatcher itself; slave is the counter/actuator side
   modport master (
      input  clk_en_i, hay_pendiente_i, listo_i, limpiar_i,
      output tirar_o, decrementar_o, ocupado_o, error_o, tiros_o
   );

   modport slave (
      output clk_en_i, hay_pendiente_i, listo_i, limpiar_i,
      input  tirar_o, decrementar_o, ocupado_o, error_o, tiros_o
   );

endinterface

// File: rtl/despachador_tiros_temporizador.sv
// Tick-driven down-counter used by the dispatcher for pulse width, pause and ready timeout.
`timescale 1ns/1ps
module temporizador_ticks #(
   parameter int ANCHO = 5
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load_i,
   input  logic [ANCHO-1:0] valor_i,
   input  logic             tick_i,
   output logic [ANCHO-1:0] cuenta_o,
   output logic             cero_o,
   output logic             ultimo_o
);

   // Load wins over tick; the count sticks at zero instead of wrapping
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cuenta_o <= '0;
      end else if (load_i) begin
         cuenta_o <= valor_i;
      end else if (tick_i && (cuenta_o != '0)) begin
         cuenta_o <= cuenta_o - ANCHO'(1);
      end
   end

   assign cero_o   = (cuenta_o == '0);
   assign ultimo_o = tick_i && (cuenta_o == ANCHO'(1));

endmodule

// File: rtl/despachador_tiros.sv
// Throw dispatcher: drains the pending-throw counter one timed actuator pulse at a time.
// Define DESPACHADOR_CONTEO_EN to implement the tiros_o completed-throw tally.
`timescale 1ns/1ps
module despachador_tiros #(
   parameter int ANCHO_PULSO = 4,
   parameter int PAUSA       = 2,
   parameter int TIMEOUT     = 16,
   parameter int ANCHO_TMR   = 5
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   despachador_tiros_if.master bus
);

   import despachador_pkg::*;

   estado_t              estado;
   estado_t              siguiente;
   logic                 tmr_carga;
   logic [ANCHO_TMR-1:0] tmr_valor;
   logic                 tmr_tick;
   logic [ANCHO_TMR-1:0] tmr_cuenta;
   logic                 tmr_cero;
   logic                 tmr_ultimo;
   logic                 expira;
   logic                 tirar;
   logic                 decrementar;
   logic                 ocupado;
   logic                 error_r;

   assign tmr_tick = bus.clk_en_i &&
                     ((estado == ESPERA_LISTO) || (estado == PULSO) ||
                      (estado == despachador_pkg::PAUSA));

   // A timer sitting at zero in a timed state must still let the sequence advance
   assign expira = tmr_ultimo || (tmr_tick && tmr_cero);

   temporizador_ticks #(
      .ANCHO (ANCHO_TMR)
   ) u_temporizador (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .load_i   (tmr_carga),
      .valor_i  (tmr_valor),
      .tick_i   (tmr_tick),
      .cuenta_o (tmr_cuenta),
      .cero_o   (tmr_cero),
      .ultimo_o (tmr_ultimo)
   );

   always_comb begin
      siguiente = estado;
      tmr_carga = 1'b0;
      tmr_valor = '0;
      case (estado)
         REPOSO: begin
            if (bus.hay_pendiente_i) begin
               siguiente = ESPERA_LISTO;
               tmr_carga = 1'b1;
               tmr_valor = ANCHO_TMR'(TIMEOUT);
            end
         end
         ESPERA_LISTO: begin
            if (bus.listo_i) begin
               siguiente = PULSO;
               tmr_carga = 1'b1;
               tmr_valor = ANCHO_TMR'(ANCHO_PULSO);
            end else if (expira) begin
               siguiente = ERROR;
            end
         end
         PULSO: begin
            if (expira) begin
               siguiente = DECREMENTAR;
            end
         end
         DECREMENTAR: begin
            // Leave only on the edge the counter samples the request: one decrement per throw
            if (bus.clk_en_i) begin
               siguiente = despachador_pkg::PAUSA;
               tmr_carga = 1'b1;
               tmr_valor = ANCHO_TMR'(PAUSA);
            end
         end
         despachador_pkg::PAUSA: begin
            if (expira) begin
               siguiente = REPOSO;
            end
         end
         ERROR: begin
            if (bus.limpiar_i) begin
               siguiente = REPOSO;
            end
         end
         default: begin
            siguiente = REPOSO;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         estado      <= REPOSO;
         tirar       <= 1'b0;
         decrementar <= 1'b0;
         ocupado     <= 1'b0;
         error_r     <= 1'b0;
      end else begin
         estado      <= siguiente;
         tirar       <= (siguiente == PULSO);
         decrementar <= (siguiente == DECREMENTAR);
         ocupado     <= es_ocupado(siguiente);
         error_r     <= (siguiente == ERROR);
      end
   end

   assign bus.tirar_o       = tirar;
   assign bus.decrementar_o = decrementar;
   assign bus.ocupado_o     = ocupado;
   assign bus.error_o       = error_r;

`ifdef DESPACHADOR_CONTEO_EN
   logic [ANCHO_TIROS-1:0] tiros;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tiros <= '0;
      end else if ((estado == DECREMENTAR) && bus.clk_en_i) begin
         tiros <= tiros + ANCHO_TIROS'(1);
      end
   end

   assign bus.tiros_o = tiros;
`else
   assign bus.tiros_o = '0;
`endif

endmodule

// File: tb/tb_despachador_tiros.sv
// Bench for despachador_tiros: counter/actuator environment, cycle model checked every clock, directed scenarios.
`timescale 1ns/1ps
module tb_despachador_tiros;

   localparam int ANCHO_PULSO = 4;
   localparam int PAUSA_T     = 2;
   localparam int TIMEOUT     = 16;

   localparam int F_IDLE  = 0;
   localparam int F_WAIT  = 1;
   localparam int F_PULSE = 2;
   localparam int F_DEC   = 3;
   localparam int F_PAUSE = 4;
   localparam int F_ERR   = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clk_en = 1'b0;
   logic listo = 1'b0;
   logic limpiar = 1'b0;
   logic carga = 1'b0;
   logic inc = 1'b0;
   int   carga_val = 0;
   int   modo = 0;
   int   div = 0;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   despachador_tiros_if bus();

   despachador_tiros #(
      .ANCHO_PULSO (ANCHO_PULSO),
      .PAUSA       (PAUSA_T),
      .TIMEOUT     (TIMEOUT),
      .ANCHO_TMR   (5)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   // Pending-throw counter environment
   int cnt = 0;
   int decs = 0;

   assign bus.clk_en_i        = clk_en;
   assign bus.listo_i         = listo;
   assign bus.limpiar_i       = limpiar;
   assign bus.hay_pendiente_i = (cnt != 0);

   always @(posedge clk) begin
      if (carga) cnt <= carga_val;
      else cnt <= cnt + (inc ? 1 : 0) - ((clk_en && bus.decrementar_o) ? 1 : 0);
      if (clk_en && bus.decrementar_o) decs <= decs + 1;
   end

   // modo 0: tick every 4th clk, 1: every clk, 2: held low
   initial begin
      forever begin
         @(negedge clk);
         div = div + 1;
         clk_en = (modo == 1) ? 1'b1 : ((modo == 2) ? 1'b0 : ((div % 4) == 0));
      end
   end

   // Reference behaviour: phase plus remaining ticks
   int m_fase = F_IDLE;
   int m_falta = 0;
   int m_tiros = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_fase  <= F_IDLE;
         m_falta <= 0;
         m_tiros <= 0;
      end else begin
         case (m_fase)
            F_IDLE:  if (cnt != 0) begin m_fase <= F_WAIT; m_falta <= TIMEOUT; end
            F_WAIT:  if (listo) begin m_fase <= F_PULSE; m_falta <= ANCHO_PULSO; end
                     else if (clk_en) begin
                        if (m_falta == 1) m_fase <= F_ERR;
                        m_falta <= m_falta - 1;
                     end
            F_PULSE: if (clk_en) begin
                        if (m_falta == 1) m_fase <= F_DEC;
                        m_falta <= m_falta - 1;
                     end
            F_DEC:   if (clk_en) begin
                        m_fase  <= F_PAUSE;
                        m_falta <= PAUSA_T;
                        m_tiros <= (m_tiros + 1) % 256;
                     end
            F_PAUSE: if (clk_en) begin
                        if (m_falta == 1) m_fase <= F_IDLE;
                        m_falta <= m_falta - 1;
                     end
            F_ERR:   if (limpiar) m_fase <= F_IDLE;
            default: m_fase <= F_IDLE;
         endcase
      end
   end

   function automatic int tiros_esperado(input int v);
`ifdef DESPACHADOR_CONTEO_EN
      return v % 256;
`else
      return 0 * v;
`endif
   endfunction

   task automatic checkOutput(input string nombre, input int actual, input int esperado);
      n_checks++;
      if (actual != esperado) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", nombre, actual, esperado, $time);
      end
   endtask

   // Per-cycle comparison against the model, plus pulse/tick/error monitors
   logic prev_tirar = 1'b0;
   logic prev_ocup = 1'b0;
   logic prev_err = 1'b0;
   int   ticks_pulso = 0;
   int   ult_ticks_pulso = 0;
   int   n_pulsos = 0;
   int   ticks_ocup = 0;
   int   n_errores = 0;

   always @(posedge clk) begin
      #2;
      checkOutput("tirar_o", int'(bus.tirar_o), int'(m_fase == F_PULSE));
      checkOutput("decrementar_o", int'(bus.decrementar_o), int'(m_fase == F_DEC));
      checkOutput("ocupado_o", int'(bus.ocupado_o), int'(m_fase != F_IDLE && m_fase != F_ERR));
      checkOutput("error_o", int'(bus.error_o), int'(m_fase == F_ERR));
      checkOutput("tiros_o", int'(bus.tiros_o), tiros_esperado(m_tiros));
      if (prev_tirar && clk_en) ticks_pulso++;
      if (bus.tirar_o && !prev_tirar) ticks_pulso = 0;
      if (!bus.tirar_o && prev_tirar) begin
         n_pulsos++;
         ult_ticks_pulso = ticks_pulso;
      end
      if (prev_ocup && clk_en) ticks_ocup++;
      if (bus.ocupado_o && !prev_ocup) ticks_ocup = 0;
      if (bus.error_o && !prev_err) n_errores++;
      prev_tirar = bus.tirar_o;
      prev_ocup  = bus.ocupado_o;
      prev_err   = bus.error_o;
   end

   task automatic applyStimulus(input int valor, input logic rdy);
      @(negedge clk);
      listo     = rdy;
      carga_val = valor;
      carga     = 1'b1;
      @(negedge clk);
      carga     = 1'b0;
   endtask

   task automatic esperar_reposo(input int max_ciclos, input string nombre);
      int  n = 0;
      logic hecho;
      do begin
         @(negedge clk);
         n++;
         hecho = (cnt == 0) && !bus.ocupado_o && !bus.error_o;
      end while (!hecho && n < max_ciclos);
      checkOutput(nombre, int'(hecho), 1);
   endtask

   task automatic esperar_senal(input int cual, input int max_ciclos, input string nombre);
      int   n = 0;
      logic visto;
      do begin
         @(negedge clk);
         n++;
         visto = (cual == 0) ? bus.tirar_o : ((cual == 1) ? bus.decrementar_o : bus.error_o);
      end while (!visto && n < max_ciclos);
      checkOutput(nombre, int'(visto), 1);
   endtask

   initial begin
      int p0;
      int d0;
      int e0;
      int n_tick;
      int it;

      repeat (3) @(negedge clk);
      checkOutput("reset tirar_o", int'(bus.tirar_o), 0);
      checkOutput("reset decrementar_o", int'(bus.decrementar_o), 0);
      checkOutput("reset ocupado_o", int'(bus.ocupado_o), 0);
      checkOutput("reset error_o", int'(bus.error_o), 0);
      checkOutput("reset tiros_o", int'(bus.tiros_o), 0);
      rst_n = 1'b1;

      $display("[TB] three queued throws");
      applyStimulus(3, 1'b1);
      esperar_reposo(600, "t1 drained");
      checkOutput("t1 pulses", n_pulsos, 3);
      checkOutput("t1 pulse ticks", ult_ticks_pulso, 4);
      checkOutput("t1 decrements", decs, 3);
      checkOutput("t1 counter", cnt, 0);
      checkOutput("t1 tiros_o", int'(bus.tiros_o), tiros_esperado(3));

      $display("[TB] actuator never ready");
      p0 = n_pulsos;
      applyStimulus(1, 1'b0);
      esperar_senal(2, 300, "t2 error raised");
      checkOutput("t2 ticks to error", ticks_ocup, 16);
      checkOutput("t2 no pulse", n_pulsos, p0);
      repeat (20) @(negedge clk);
      checkOutput("t2 error sticky", int'(bus.error_o), 1);
      limpiar = 1'b1;
      @(negedge clk);
      limpiar = 1'b0;
      listo   = 1'b1;
      esperar_reposo(200, "t2 recovered");
      checkOutput("t2 one throw", n_pulsos, p0 + 1);

      $display("[TB] ready arrives on the last timeout tick");
      p0 = n_pulsos;
      e0 = n_errores;
      applyStimulus(1, 1'b0);
      n_tick = 0;
      it = 0;
      begin : espera_tick16
         logic empezado;
         empezado = 1'b0;
         while (n_tick < 16 && it < 300) begin
            @(negedge clk);
            #1;
            it++;
            if (bus.ocupado_o) empezado = 1'b1;
            if (empezado && clk_en) n_tick++;
         end
      end
      checkOutput("t2b tick 16 reached", n_tick, 16);
      listo = 1'b1;
      esperar_reposo(200, "t2b drained");
      checkOutput("t2b no error", n_errores, e0);
      checkOutput("t2b one throw", n_pulsos, p0 + 1);

      $display("[TB] decrement held without ticks");
      d0 = decs;
      applyStimulus(1, 1'b1);
      esperar_senal(1, 200, "t3 decrement seen");
      modo = 2;
      repeat (10) @(negedge clk);
      checkOutput("t3 request held", int'(bus.decrementar_o), 1);
      checkOutput("t3 counter unchanged", cnt, 1);
      checkOutput("t3 no decrement yet", decs, d0);
      modo = 0;
      esperar_reposo(200, "t3 drained");
      checkOutput("t3 exactly one", decs, d0 + 1);

      $display("[TB] increments during a throw");
      p0 = n_pulsos;
      d0 = decs;
      applyStimulus(1, 1'b1);
      esperar_senal(0, 200, "t4 pulse seen");
      @(negedge clk); inc = 1'b1;
      @(negedge clk); inc = 1'b0;
      @(negedge clk); inc = 1'b1;
      @(negedge clk); inc = 1'b0;
      esperar_reposo(800, "t4 drained");
      checkOutput("t4 three throws", n_pulsos, p0 + 3);
      checkOutput("t4 three decrements", decs, d0 + 3);

      $display("[TB] asynchronous reset mid-pulse");
      applyStimulus(1, 1'b1);
      esperar_senal(0, 200, "t5 pulse seen");
      repeat (3) @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("t5 tirar_o drops", int'(bus.tirar_o), 0);
      checkOutput("t5 decrementar_o", int'(bus.decrementar_o), 0);
      checkOutput("t5 ocupado_o drops", int'(bus.ocupado_o), 0);
      checkOutput("t5 tiros_o cleared", int'(bus.tiros_o), 0);
      carga_val = 0;
      carga = 1'b1;
      @(negedge clk);
      carga = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] tally wrap");
      modo = 1;
      applyStimulus(255, 1'b1);
      esperar_reposo(4000, "t6 drained 255");
      checkOutput("t6 tiros_o 255", int'(bus.tiros_o), tiros_esperado(255));
      applyStimulus(1, 1'b1);
      esperar_reposo(200, "t6 drained wrap");
      checkOutput("t6 tiros_o wraps", int'(bus.tiros_o), tiros_esperado(256));
      checkOutput("t6 counter", cnt, 0);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
